mul6u_share_arb: RTL and testbench
==================================

# mul6u_share_arb

Round-robin arbiter and two-stage sequencer that time-shares one external 6x6 unsigned approximate multiplier among NREQ requesters. It sits between the requesting datapath units and the multiplier variant under study, so any pareto-set multiplier can be swapped in at the `mul_a`/`mul_b`/`mul_o` ports without touching the requesters. Each request gets exactly one response, tagged with the requester ID. Back-pressure propagates from the response port to the grants.

## Interface
- NREQ, 4: number of requesters; range 2..8.
- IDW, 2: ID width; must equal ceil(log2(NREQ)).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  6*NREQ  operand A; requester i uses bits [6i+5:6i].
- req_b  in  6*NREQ  operand B; same packing as `req_a`.
- req_ready  out  NREQ  one-hot-or-zero grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- mul_a  out  6  operand A to the external multiplier.
- mul_b  out  6  operand B to the external multiplier.
- mul_o  in  12  combinational product from the external multiplier.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accepted by the sink.
- rsp_o  out  12  product.
- rsp_id  out  IDW  index of the requester that issued the request.
- txn_cnt  out  16  count of completed responses; wraps at 65535 -> 0.

## Operation
- Stage 1 (operand register): `s1_v`, `s1_a`, `s1_b`, `s1_id`. `mul_a = s1_a` and `mul_b = s1_b`, driven directly from registers.
- Stage 2 (result register): `rsp_valid`, `rsp_o`, `rsp_id`. Loads `mul_o` and `s1_id` when stage 1 is valid and advancing.
- Advance conditions:
  - `adv2 = !rsp_valid | rsp_ready`
  - `adv1 = !s1_v | adv2`
- Arbitration is combinational:
  - When `adv1 = 1`, grant the lowest index i at or after pointer `ptr` (cyclic order) with `req_valid[i] = 1`. Drive `req_ready[i] = 1`; all other bits are 0.
  - When `adv1 = 0` or no request is valid, `req_ready` is all zero.
  - `req_ready` never depends on `rsp_ready` except through `adv1`.
- Pointer update: on an accept by requester i, `ptr <= (i+1) mod NREQ`. Otherwise `ptr` holds.
- Stage 1 load: on an accept, load operands and ID, set `s1_v = 1`. If `adv1` and no accept, `s1_v <= 0`.
- Stage 2 update on `adv2`:
  - Load `rsp_valid <= s1_v`.
  - Load `rsp_o` and `rsp_id` only when `s1_v = 1`.
  - When `rsp_valid = 1` and `rsp_ready = 0`, `rsp_o` and `rsp_id` are held stable.
- `txn_cnt` increments on each `rsp_valid & rsp_ready` cycle.
- Arithmetic: `rsp_o` is exactly the `mul_o` value sampled. The block applies no correction, so the approximation error is the multiplier's.
- Requesters must hold `req_a`/`req_b` stable while `req_valid` is high and not yet accepted. A requester may drop `req_valid` before acceptance without effect.

## Timing
- Reset (async assert, sync release): `ptr = 0`, `s1_v = 0`, `s1_a = 0`, `s1_b = 0`, `s1_id = 0`, `rsp_valid = 0`, `rsp_o = 0`, `rsp_id = 0`, `txn_cnt = 0`. Outputs `mul_a = mul_b = 0` and `req_ready = 0` while `rst_n = 0`.
- Latency: accept at edge N -> `rsp_valid` high after edge N+1, with `rsp_ready` held high. Throughput is 1 response per cycle.
- Full stall: `rsp_valid = 1`, `rsp_ready = 0`, `s1_v = 1`.
  - `req_ready = 0`, and both stages hold.
  - When `rsp_ready` rises, the stage-2 result is consumed and the stage-1 entry moves into stage 2 in the same cycle. A new grant is allowed in that same cycle.
- Partial stall: stage 2 is full, stage 1 is empty, `rsp_ready = 0`. One request can still be accepted into stage 1.
- Simultaneous requests: exactly one grant per cycle. Any continuously valid requester is granted within NREQ accepts.
- Pointer wrap: a grant to NREQ-1 sets `ptr = 0`.
- Reset mid-operation: in-flight stage-1 and stage-2 contents are discarded. No response is produced for them.

## Test plan
- Single request: only `req_valid[2] = 1` with a = 7, b = 9 and `rsp_ready = 1`.
  - Required: `req_ready = 4'b0100` in the request cycle.
  - Two cycles later: `rsp_valid = 1`, `rsp_id = 2`, `rsp_o` equals the multiplier model's output for (7, 9), and `txn_cnt = 1`.
- Round-robin: all four requesters hold `req_valid = 1` for 8 cycles after reset.
  - Required grant order: 0, 1, 2, 3, 0, 1, 2, 3.
  - Required: 8 responses back-to-back with IDs in that order.
- Back-pressure: hold `rsp_ready = 0` for 5 cycles with requesters 1 and 3 active.
  - Required: exactly 2 accepts (stages 1 and 2 fill), after which `req_ready = 0`.
  - Required: `rsp_o` and `rsp_id` stable throughout the stall.
  - On release, responses appear on consecutive cycles with no loss or duplication.
- Pointer wrap and skip: only requesters 3 and 1 valid, with `ptr = 2`.
  - Required grants: 3, then 1, then 3.
- Reset mid-flight: assert `rst_n = 0` while `s1_v = 1` and `rsp_valid = 1`.
  - Required: all outputs go to reset values immediately.
  - Required: no response is emitted after release, and `ptr = 0`.
- Counter wrap: preload via 65536 transactions.
  - Required: `txn_cnt` goes 65535 -> 0.
  - Required: randomized operands with scoreboard compare of `rsp_o` against the multiplier model for all 4096 operand pairs.

Source files
------------

// File: rtl/mul6u_share_arb.sv
// Round-robin arbiter plus two-stage operand/result pipeline that time-shares one
// external 6x6 unsigned (approximate) multiplier among NREQ requesters.
module mul6u_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [6*NREQ-1:0] req_a,
  input  logic [6*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [5:0]        mul_a,
  output logic [5:0]        mul_b,
  input  logic [11:0]       mul_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [11:0]       rsp_o,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       txn_cnt
);

  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  ptr_next;
  logic            s1_v;
  logic [5:0]      s1_a;
  logic [5:0]      s1_b;
  logic [IDW-1:0]  s1_id;

  logic            adv1;
  logic            adv2;
  logic            accept;
  logic            found;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  scan_id;
  logic [IDW:0]    scan_sum;
  logic [NREQ-1:0] grant;

  logic [5:0]      op_a [NREQ];
  logic [5:0]      op_b [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_a[g] = req_a[6*g +: 6];
    assign op_b[g] = req_b[6*g +: 6];
  end

  assign adv2 = !rsp_valid || rsp_ready;
  assign adv1 = !s1_v || adv2;

  // Scan cyclically from ptr; the grant is also gated by reset so nothing is
  // offered while the pipeline is being cleared.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      scan_id = scan_sum[IDW-1:0];
      if (!found && req_valid[scan_id]) begin
        found    = 1'b1;
        grant_id = scan_id;
      end
    end
    if (found && adv1 && rst_n) begin
      grant[grant_id] = 1'b1;
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign ptr_next  = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      s1_v  <= 1'b0;
      s1_a  <= '0;
      s1_b  <= '0;
      s1_id <= '0;
    end else if (accept) begin
      ptr   <= ptr_next;
      s1_v  <= 1'b1;
      s1_a  <= op_a[grant_id];
      s1_b  <= op_b[grant_id];
      s1_id <= grant_id;
    end else if (adv1) begin
      s1_v  <= 1'b0;
    end
  end

  // Result payload only moves when a real entry arrives, so a stalled or
  // drained response keeps its last product and ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_o     <= '0;
      rsp_id    <= '0;
    end else if (adv2) begin
      rsp_valid <= s1_v;
      if (s1_v) begin
        rsp_o  <= mul_o;
        rsp_id <= s1_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
    end else if (rsp_valid && rsp_ready) begin
      txn_cnt <= txn_cnt + 16'd1;
    end
  end

  assign mul_a = s1_a;
  assign mul_b = s1_b;

endmodule

// File: tb/tb_mul6u_share_arb.sv
// Directed bench for mul6u_share_arb: scoreboard of accepted requests versus
// responses, using an asymmetric approximate multiplier model on mul_a/mul_b.
module tb_mul6u_share_arb;

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] prod;
  } sb_entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req_valid;
  logic [23:0] req_a;
  logic [23:0] req_b;
  logic [3:0]  req_ready;
  logic [5:0]  mul_a;
  logic [5:0]  mul_b;
  logic [11:0] mul_o;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] rsp_o;
  logic [1:0]  rsp_id;
  logic [15:0] txn_cnt;

  logic [5:0]  op_a [4];
  logic [5:0]  op_b [4];

  sb_entry_t   sb [$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_cnt = '0;
  int          last_grant = -1;
  bit          refresh_ops = 1'b0;
  int          pair_k = 0;
  int          pair_off = 0;
  bit          seen [4096];
  int          covered = 0;

  always #5 clk = ~clk;

  // Stand-in approximate multiplier: ignores b[0], so it is not symmetric.
  function automatic logic [11:0] approx_mul(input logic [5:0] a, input logic [5:0] b);
    return 12'(a) * 12'({b[5:1], 1'b0});
  endfunction

  assign mul_o = approx_mul(mul_a, mul_b);

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign req_a[6*g +: 6] = op_a[g];
    assign req_b[6*g +: 6] = op_b[g];
  end

  mul6u_share_arb #(.NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_o     (mul_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_o     (rsp_o),
    .rsp_id    (rsp_id),
    .txn_cnt   (txn_cnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setOps(input logic [1:0] id, input logic [5:0] a, input logic [5:0] b);
    op_a[id] = a;
    op_b[id] = b;
  endtask

  // Odd stride over 4096 visits every operand pair once per 4096 draws.
  task automatic loadNextPair(input logic [1:0] id);
    logic [11:0] p;
    p = 12'(pair_k * 2477 + pair_off);
    op_a[id] = p[11:6];
    op_b[id] = p[5:0];
    pair_k++;
  endtask

  task automatic observe();
    sb_entry_t e;
    last_grant = -1;
    checkOutput("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        last_grant = i;
        e.id   = 2'(i);
        e.prod = approx_mul(op_a[i], op_b[i]);
        sb.push_back(e);
        if (!seen[{op_a[i], op_b[i]}]) begin
          seen[{op_a[i], op_b[i]}] = 1'b1;
          covered++;
        end
      end
    end
    checkOutput("txn_cnt", 32'(txn_cnt), 32'(model_cnt));
    if (rsp_valid && rsp_ready) begin
      checkOutput("rsp_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
        checkOutput("rsp_o", 32'(rsp_o), 32'(e.prod));
      end
      model_cnt = model_cnt + 16'd1;
    end
  endtask

  // One cycle: drive at the falling edge, settle, then record handshakes.
  task automatic applyStimulus(input logic [3:0] valid, input logic ready);
    @(negedge clk);
    if (refresh_ops && last_grant >= 0) begin
      loadNextPair(2'(last_grant));
    end
    req_valid = valid;
    rsp_ready = ready;
    #1;
    observe();
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    sb.delete();
    model_cnt = '0;
    last_grant = -1;
    rst_n = 1'b1;
  endtask

  initial begin
    int rr_rsp;
    int bp_acc;
    int rel_rsp;
    int guard;
    int exp_g [3];

    rr_rsp = 0;
    bp_acc = 0;
    rel_rsp = 0;
    exp_g = '{3, 1, 3};
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) setOps(2'(i), 6'(i + 3), 6'(i + 20));

    #2 rst_n = 1'b0;
    #5;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_mul_a", 32'(mul_a), 32'd0);
    checkOutput("rst_mul_b", 32'(mul_b), 32'd0);
    checkOutput("rst_rsp_o", 32'(rsp_o), 32'd0);
    checkOutput("rst_txn_cnt", 32'(txn_cnt), 32'd0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;

    $display("[TB] single request");
    setOps(2'd2, 6'd7, 6'd9);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("single_grant", 32'(req_ready), 32'b0100);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_lat_rsp", 32'(rsp_valid), 32'd0);
    checkOutput("single_mul_a", 32'(mul_a), 32'd7);
    checkOutput("single_mul_b", 32'(mul_b), 32'd9);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("single_rsp_id", 32'(rsp_id), 32'd2);
    checkOutput("single_rsp_o", 32'(rsp_o), 32'(approx_mul(6'd7, 6'd9)));
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_txn", 32'(txn_cnt), 32'd1);

    $display("[TB] round robin");
    resetDut();
    for (int i = 0; i < 4; i++) setOps(2'(i), 6'(i * 9 + 5), 6'(i * 13 + 2));
    refresh_ops = 1'b1;
    for (int c = 0; c < 12; c++) begin
      applyStimulus((c < 8) ? 4'hF : 4'h0, 1'b1);
      if (c < 8) checkOutput("rr_grant", 32'(last_grant), 32'(c % 4));
      if (c >= 2 && c <= 9 && rsp_valid) rr_rsp++;
    end
    refresh_ops = 1'b0;
    checkOutput("rr_rsp_count", 32'(rr_rsp), 32'd8);
    checkOutput("rr_drain", 32'(sb.size()), 32'd0);

    $display("[TB] back-pressure");
    setOps(2'd1, 6'd45, 6'd23);
    setOps(2'd3, 6'd62, 6'd51);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b1010, 1'b0);
      if (last_grant >= 0) bp_acc++;
      if (c >= 2) begin
        checkOutput("bp_ready_low", 32'(req_ready), 32'd0);
        checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("bp_rsp_id", 32'(rsp_id), 32'd1);
        checkOutput("bp_rsp_o", 32'(rsp_o), 32'(approx_mul(6'd45, 6'd23)));
      end
    end
    checkOutput("bp_accepts", 32'(bp_acc), 32'd2);
    applyStimulus(4'b1010, 1'b1);
    checkOutput("bp_regrant", 32'(req_ready), 32'b0010);
    if (rsp_valid) rel_rsp++;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(4'b0000, 1'b1);
      if (rsp_valid) rel_rsp++;
    end
    checkOutput("bp_release_rsps", 32'(rel_rsp), 32'd3);
    checkOutput("bp_drain", 32'(sb.size()), 32'd0);

    $display("[TB] pointer wrap and skip");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b1010, 1'b1);
      checkOutput("wrap_grant", 32'(last_grant), 32'(exp_g[c]));
    end
    for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 1'b1);
    checkOutput("wrap_drain", 32'(sb.size()), 32'd0);

    $display("[TB] reset mid-flight");
    setOps(2'd2, 6'd33, 6'd17);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("mid_stall_ready", 32'(req_ready), 32'd0);
    checkOutput("mid_stall_valid", 32'(rsp_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 32'(req_ready), 32'd0);
    checkOutput("mid_rst_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_rsp_o", 32'(rsp_o), 32'd0);
    checkOutput("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("mid_rst_mul_a", 32'(mul_a), 32'd0);
    checkOutput("mid_rst_mul_b", 32'(mul_b), 32'd0);
    checkOutput("mid_rst_txn", 32'(txn_cnt), 32'd0);
    sb.delete();
    model_cnt = '0;
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0000, 1'b1);
      checkOutput("mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    applyStimulus(4'hF, 1'b1);
    checkOutput("mid_ptr0", 32'(req_ready), 32'b0001);
    for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 1'b1);
    checkOutput("mid_drain", 32'(sb.size()), 32'd0);

    $display("[TB] counter wrap with full operand sweep");
    pair_off = int'($urandom_range(0, 4095));
    pair_k = 0;
    covered = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < 4; i++) loadNextPair(2'(i));
    refresh_ops = 1'b1;
    guard = 0;
    while (txn_cnt !== 16'hFFFF && guard < 70000) begin
      applyStimulus(4'hF, 1'b1);
      guard++;
    end
    checkOutput("cnt_max", 32'(txn_cnt), 32'hFFFF);
    applyStimulus(4'hF, 1'b1);
    checkOutput("cnt_wrap", 32'(txn_cnt), 32'd0);
    refresh_ops = 1'b0;
    for (int c = 0; c < 4; c++) applyStimulus(4'b0000, 1'b1);
    checkOutput("sweep_drain", 32'(sb.size()), 32'd0);
    checkOutput("pairs_covered", 32'(covered), 32'd4096);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
